// File: rtl/midi_uart_tx.sv
// rtl/midi_uart_tx.sv - MIDI OUT 8N1 serial transmitter with byte FIFO
// Optional enqueue-side running-status filter: define MIDI_RUNNING_STATUS_EN
module midi_uart_tx #(
    parameter int CLK_DIV = 1024,
    parameter int FIFO_AW = 2
) (
    input  logic             clk32,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [7:0]       din,
    input  logic             clr_ovf,
    output logic             txd,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic [FIFO_AW:0] level
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_txd;
    logic               w_line;
    logic               w_cnt_end;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic [FIFO_AW:0]   w_level_nxt;
    logic               r_full;
    logic               r_empty;
    logic               r_ovf;
    logic               w_pop;
    logic               w_want;
    logic               w_push;
    logic               w_drop;
    logic               w_filtered;
    logic [7:0]         w_head;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] r_last_status;
    logic       w_is_chan;
    logic       w_is_common;

    // Channel status 0x80..0xEF repeats are redundant on the wire; sysex/common resets the context.
    assign w_is_chan   = din[7] & (din[6:4] != 3'b111);
    assign w_is_common = (din[7:3] == 5'b11110);
    assign w_filtered  = w_is_chan & (din == r_last_status);

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_last_status <= 8'h00;
        end else if (w_push && w_is_chan) begin
            r_last_status <= din;
        end else if ((w_push && w_is_common) || clr_ovf) begin
            r_last_status <= 8'h00;
        end
    end
`else
    assign w_filtered = 1'b0;
`endif

    assign w_want      = wr & ~w_filtered;
    assign w_push      = w_want & (~r_full | w_pop);
    assign w_drop      = w_want & r_full & ~w_pop;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_level_nxt = r_level + (FIFO_AW + 1)'(w_push) - (FIFO_AW + 1)'(w_pop);
    assign w_cnt_end   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk32) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);
            // A fresh overflow beats a simultaneous clear so no drop goes unreported.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_line;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_line      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_line    = 1'b0;
                w_cnt_nxt = w_cnt_end ? '0 : r_cnt + 1'b1;
                if (w_cnt_end) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_line    = r_shift[0];
                w_cnt_nxt = w_cnt_end ? '0 : r_cnt + 1'b1;
                if (w_cnt_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                w_line    = 1'b1;
                w_cnt_nxt = w_cnt_end ? '0 : r_cnt + 1'b1;
                // Chain straight into the next start bit so queued bytes leave with no idle gap.
                if (w_cnt_end) begin
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign txd   = r_txd;
    assign busy  = (r_state != S_IDLE) | ~r_empty;
    assign full  = r_full;
    assign empty = r_empty;
    assign ovf   = r_ovf;
    assign level = r_level;

endmodule

// File: tb/tb_midi_uart_tx.sv
// tb/tb_midi_uart_tx.sv - scoreboard bench for midi_uart_tx with a line-side frame decoder
module tb_midi_uart_tx;

    localparam int D  = 64;
    localparam int AW = 2;

    logic        clk32   = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr      = 1'b0;
    logic [7:0]  din     = 8'h00;
    logic        clr_ovf = 1'b0;
    logic        txd;
    logic        busy;
    logic        full;
    logic        empty;
    logic        ovf;
    logic [AW:0] level;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         fall_q[$];

    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh  = 8'h00;
    int         mon_err = 0;
    logic       busy_q  = 1'b0;

    midi_uart_tx #(.CLK_DIV(D), .FIFO_AW(AW)) dut (
        .clk32   (clk32),
        .rst_n   (rst_n),
        .wr      (wr),
        .din     (din),
        .clr_ovf (clr_ovf),
        .txd     (txd),
        .busy    (busy),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .level   (level)
    );

    always #5 clk32 = ~clk32;

    always @(posedge clk32) cyc <= cyc + 1;

    // Line decoder: samples each bit at its centre, counted from the first low sample.
    always @(negedge clk32) begin
        if (!rst_n) begin
            mon_act <= 1'b0;
            mon_cnt <= 0;
        end else if (!mon_act) begin
            if (txd === 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
                start_q.push_back(cyc);
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt % D == D / 2) begin
                if (mon_cnt / D == 0) begin
                    if (txd !== 1'b0) mon_err <= mon_err + 1;
                end else if (mon_cnt / D <= 8) begin
                    mon_sh <= {txd, mon_sh[7:1]};
                end else begin
                    if (txd !== 1'b1) mon_err <= mon_err + 1;
                    rx_q.push_back(mon_sh);
                    mon_act <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk32) begin
        busy_q <= busy;
        if (busy_q === 1'b1 && busy === 1'b0) fall_q.push_back(cyc);
    end

    task clear_sb;
        exp_q.delete();
        rx_q.delete();
        start_q.delete();
        fall_q.delete();
    endtask

    task wait_rx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < (n + 2) * 10 * D; i++) begin
            @(negedge clk32);
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task write_one(input logic [7:0] b);
        for (int i = 0; i < 20 * D && full === 1'b1; i++) @(negedge clk32);
        @(negedge clk32);
        wr  = 1'b1;
        din = b;
        @(negedge clk32);
        wr  = 1'b0;
    endtask

    task test_reset;
        int bad;
        rst_n = 1'b0;
        repeat (3) @(negedge clk32);
        tests++; if (txd !== 1'b1)   begin fails++; $display("FAIL reset_txd got %b want 1", txd); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (level !== '0)   begin fails++; $display("FAIL reset_level got %0d want 0", level); end
        tests++; if (ovf !== 1'b0)   begin fails++; $display("FAIL reset_ovf got %b want 0", ovf); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (full !== 1'b0)  begin fails++; $display("FAIL reset_full got %b want 0", full); end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk32);
            if (txd !== 1'b1) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL idle_txd low for %0d cycles want 0", bad); end
        tests++; if (start_q.size() != 0) begin fails++; $display("FAIL idle_frames got %0d want 0", start_q.size()); end
    endtask

    task test_single;
        int  wcyc;
        int  err0;
        bit  ok;
        logic [7:0] got;
        logic [7:0] want;
        clear_sb();
        err0 = mon_err;
        @(negedge clk32);
        wr = 1'b1; din = 8'h90; wcyc = cyc + 1;
        exp_q.push_back(8'h90);
        @(negedge clk32);
        wr = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", busy); end
        wait_rx(1, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_rx_timeout got %0d frames want 1", rx_q.size()); end
        tests++;
        if (start_q.size() == 0 || start_q[0] != wcyc + 2) begin
            fails++; $display("FAIL single_latency got start %0d want %0d", (start_q.size() > 0) ? start_q[0] : -1, wcyc + 2);
        end
        repeat (D) @(negedge clk32);
        tests++;
        if (fall_q.size() != 1 || start_q.size() == 0 || fall_q[0] != start_q[0] + 10 * D - 1) begin
            fails++; $display("FAIL single_busy_fall got %0d want %0d", (fall_q.size() > 0) ? fall_q[0] : -1, wcyc + 1 + 10 * D);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            tests++; if (got !== want) begin fails++; $display("FAIL single_byte got %02h want %02h", got, want); end
        end
        tests++; if (mon_err != err0) begin fails++; $display("FAIL single_framing got %0d errors want 0", mon_err - err0); end
    endtask

    task test_back_to_back;
        bit  ok;
        logic [7:0] b [3];
        logic [7:0] got;
        logic [7:0] want;
        b[0] = 8'h3C; b[1] = 8'h7F; b[2] = 8'h00;
        clear_sb();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk32);
            wr = 1'b1; din = b[i];
            exp_q.push_back(b[i]);
        end
        @(negedge clk32);
        wr = 1'b0;
        tests++; if (level !== 3'd2) begin fails++; $display("FAIL b2b_level got %0d want 2", level); end
        wait_rx(3, ok);
        tests++; if (!ok) begin fails++; $display("FAIL b2b_rx_timeout got %0d frames want 3", rx_q.size()); end
        tests++;
        if (start_q.size() != 3 || start_q[1] - start_q[0] != 10 * D || start_q[2] - start_q[1] != 10 * D) begin
            fails++; $display("FAIL b2b_gap got %0d starts, span %0d want 3 starts, span %0d", start_q.size(),
                (start_q.size() == 3) ? start_q[2] - start_q[0] : -1, 20 * D);
        end
        repeat (D) @(negedge clk32);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end got %b want 0", busy); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            tests++; if (got !== want) begin fails++; $display("FAIL b2b_byte got %02h want %02h", got, want); end
        end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_missing got %0d left want 0", exp_q.size()); end
    endtask

    task test_overflow;
        bit  ok;
        bit  gaps_ok;
        logic [7:0] got;
        logic [7:0] want;
        clear_sb();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk32);
            wr = 1'b1; din = 8'h01 + 8'(i);
            clr_ovf = (i == 5);
            if (i < 5) exp_q.push_back(8'h01 + 8'(i));
        end
        @(negedge clk32);
        wr = 1'b0; clr_ovf = 1'b0;
        tests++; if (full !== 1'b1)  begin fails++; $display("FAIL ovf_full got %b want 1", full); end
        tests++; if (level !== 3'd4) begin fails++; $display("FAIL ovf_level got %0d want 4", level); end
        tests++; if (ovf !== 1'b1)   begin fails++; $display("FAIL ovf_set_wins got %b want 1", ovf); end
        clr_ovf = 1'b1;
        @(negedge clk32);
        clr_ovf = 1'b0;
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", ovf); end
        wait_rx(5, ok);
        repeat (12 * D) @(negedge clk32);
        tests++; if (!ok || rx_q.size() != 5) begin fails++; $display("FAIL ovf_frames got %0d want 5", rx_q.size()); end
        gaps_ok = (start_q.size() == 5);
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 10 * D) gaps_ok = 1'b0;
        tests++; if (!gaps_ok) begin fails++; $display("FAIL ovf_gaps got %0d starts want 5 spaced %0d", start_q.size(), 10 * D); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            tests++; if (got !== want) begin fails++; $display("FAIL ovf_byte got %02h want %02h", got, want); end
        end
    endtask

    task test_reset_mid_frame;
        clear_sb();
        @(negedge clk32);
        wr = 1'b1; din = 8'hA5;
        @(negedge clk32);
        wr = 1'b0;
        for (int i = 0; i < 8 && start_q.size() == 0; i++) @(negedge clk32);
        repeat (2 * D) @(negedge clk32);
        tests++; if (txd !== 1'b0) begin fails++; $display("FAIL midrst_bit1 got %b want 0", txd); end
        rst_n = 1'b0;
        #1;
        tests++; if (txd !== 1'b1)   begin fails++; $display("FAIL midrst_txd got %b want 1", txd); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL midrst_empty got %b want 1", empty); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
        repeat (3) @(negedge clk32);
        rst_n = 1'b1;
        repeat (12 * D) @(negedge clk32);
        tests++; if (start_q.size() != 1 || rx_q.size() != 0) begin
            fails++; $display("FAIL midrst_resume got %0d starts %0d bytes want 1 starts 0 bytes", start_q.size(), rx_q.size());
        end
        tests++; if (txd !== 1'b1 || level !== '0) begin fails++; $display("FAIL midrst_idle got txd %b level %0d want 1 0", txd, level); end
    endtask

    task test_running_status;
        bit  ok;
        int  n;
        logic [7:0] seq [9];
        logic [7:0] got;
        logic [7:0] want;
        seq[0] = 8'h90; seq[1] = 8'h40; seq[2] = 8'h7F; seq[3] = 8'h90; seq[4] = 8'h41;
        seq[5] = 8'hF8; seq[6] = 8'h90; seq[7] = 8'hF0; seq[8] = 8'h90;
        clear_sb();
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q.push_back(8'h90); exp_q.push_back(8'h40); exp_q.push_back(8'h7F);
        exp_q.push_back(8'h41); exp_q.push_back(8'hF8); exp_q.push_back(8'hF0);
        exp_q.push_back(8'h90);
`else
        for (int i = 0; i < 9; i++) exp_q.push_back(seq[i]);
`endif
        n = exp_q.size();
        for (int i = 0; i < 7; i++) write_one(seq[i]);
        wait_rx(n - 2, ok);
        write_one(seq[7]);
        write_one(seq[8]);
        wait_rx(n, ok);
        repeat (12 * D) @(negedge clk32);
        tests++; if (!ok || rx_q.size() != n) begin fails++; $display("FAIL rs_frames got %0d want %0d", rx_q.size(), n); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rs_ovf got %b want 0", ovf); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front(); want = exp_q.pop_front();
            tests++; if (got !== want) begin fails++; $display("FAIL rs_byte got %02h want %02h", got, want); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_running_status();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
